// File: rtl/timer_pkg.sv
// Shared types and defaults for the down-timer channels.
package timer_pkg;

    typedef enum logic {T_IDLE, T_RUN} tmr_state_t;

    localparam int T_PRESCALE_DEF = 4;

endpackage

// File: rtl/down_timer_ch.sv
// One load-and-expire down-timer channel: IDLE/RUN FSM, count, reload, prescaler, expiry pulse.
module down_timer_ch
    import timer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIV   = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Tick,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    input  logic             Load_auto,
    input  logic             Abort,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Expired
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    tmr_state_t       state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic [WIDTH-1:0] reload, reload_nxt;
    logic             auto_q, auto_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             expired, expired_nxt;
    logic             div_hit;

    // With DIV=1 the prescaler sits at 0 == DIV-1, so every tick is a hit.
    assign div_hit = (presc == PW'(DIV - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= T_IDLE;
            count   <= '0;
            reload  <= '0;
            auto_q  <= 1'b0;
            presc   <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            reload  <= reload_nxt;
            auto_q  <= auto_nxt;
            presc   <= presc_nxt;
            expired <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        reload_nxt  = reload;
        auto_nxt    = auto_q;
        presc_nxt   = presc;
        expired_nxt = 1'b0;
        if (Abort) begin
            state_nxt = T_IDLE;
        end else if (Load) begin
            count_nxt  = Load_value;
            reload_nxt = Load_value;
            auto_nxt   = Load_auto;
            presc_nxt  = '0;
            state_nxt  = (Load_value != '0) ? T_RUN : T_IDLE;
        end else if (Tick && state == T_RUN) begin
            presc_nxt = div_hit ? '0 : presc + 1'b1;
            if (div_hit && count != '0) begin
                if (count == WIDTH'(1)) begin
                    expired_nxt = 1'b1;
                    if (auto_q) begin
                        count_nxt = reload;
                    end else begin
                        count_nxt = '0;
                        state_nxt = T_IDLE;
                    end
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    assign Count   = count;
    assign Busy    = (state == T_RUN);
    assign Expired = expired;

endmodule

// File: rtl/dual_down_timer.sv
// Two-channel down-timer: steers load/abort by Load_sel, decodes ticks by Slt, owns Load_ready.
module dual_down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int PRESCALE = T_PRESCALE_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Slt,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic             Load_sel,
    input  logic [WIDTH-1:0] Load_value,
    input  logic             Load_auto,
    input  logic             Abort,
    output logic [WIDTH-1:0] Count0,
    output logic [WIDTH-1:0] Count1,
    output logic             Busy0,
    output logic             Busy1,
    output logic             Expired0,
    output logic             Expired1
);

    logic ready_q;
    logic accept;

    assign accept = Load_valid && ready_q;

    // Ready drops for exactly one cycle after every handshake.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= !accept;
        end
    end

    assign Load_ready = ready_q;

    down_timer_ch #(
        .WIDTH (WIDTH),
        .DIV   (1)
    ) u_ch0 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Tick       (En && !Slt),
        .Load       (accept && !Load_sel),
        .Load_value (Load_value),
        .Load_auto  (Load_auto),
        .Abort      (Abort && !Load_sel),
        .Count      (Count0),
        .Busy       (Busy0),
        .Expired    (Expired0)
    );

    down_timer_ch #(
        .WIDTH (WIDTH),
        .DIV   (PRESCALE)
    ) u_ch1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Tick       (En && Slt),
        .Load       (accept && Load_sel),
        .Load_value (Load_value),
        .Load_auto  (Load_auto),
        .Abort      (Abort && Load_sel),
        .Count      (Count1),
        .Busy       (Busy1),
        .Expired    (Expired1)
    );

endmodule

// File: tb/tb_dual_down_timer.sv
// Self-checking bench for dual_down_timer: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_dual_down_timer;

    localparam int W = 64;
    localparam int P = 4;

    logic         Clk;
    logic         Reset_n;
    logic         En;
    logic         Slt;
    logic         Load_valid;
    logic         Load_ready;
    logic         Load_sel;
    logic [W-1:0] Load_value;
    logic         Load_auto;
    logic         Abort;
    logic [W-1:0] Count0;
    logic [W-1:0] Count1;
    logic         Busy0;
    logic         Busy1;
    logic         Expired0;
    logic         Expired1;

    int vectors;
    int miscompares;

    // Behavioural model: per-channel value, reload, auto, running flag, sub-tick count.
    logic [W-1:0] m_cnt [2];
    logic [W-1:0] m_rel [2];
    bit           m_auto[2];
    bit           m_run [2];
    bit           m_exp [2];
    int           m_sub [2];
    bit           m_ready;

    dual_down_timer #(
        .WIDTH    (W),
        .PRESCALE (P)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .En         (En),
        .Slt        (Slt),
        .Load_valid (Load_valid),
        .Load_ready (Load_ready),
        .Load_sel   (Load_sel),
        .Load_value (Load_value),
        .Load_auto  (Load_auto),
        .Abort      (Abort),
        .Count0     (Count0),
        .Count1     (Count1),
        .Busy0      (Busy0),
        .Busy1      (Busy1),
        .Expired0   (Expired0),
        .Expired1   (Expired1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = '0; m_rel[c] = '0; m_auto[c] = 0;
            m_run[c] = 0;  m_exp[c] = 0;  m_sub[c] = 0;
        end
        m_ready = 1;
    endtask

    task automatic model_step();
        bit acc;
        acc = Load_valid && m_ready;
        for (int c = 0; c < 2; c++) begin
            bit tick, ab, ld;
            tick = En && (int'(Slt) == c);
            ab   = Abort && (int'(Load_sel) == c);
            ld   = acc && (int'(Load_sel) == c);
            m_exp[c] = 0;
            if (ab) begin
                m_run[c] = 0;
            end else if (ld) begin
                m_cnt[c] = Load_value; m_rel[c] = Load_value;
                m_auto[c] = Load_auto; m_sub[c] = 0;
                m_run[c] = (Load_value != 0);
            end else if (tick && m_run[c]) begin
                m_sub[c] = m_sub[c] + 1;
                if (c == 0 || m_sub[c] == P) begin
                    m_sub[c] = 0;
                    m_cnt[c] = m_cnt[c] - 1;
                    if (m_cnt[c] == 0) begin
                        m_exp[c] = 1;
                        if (m_auto[c]) m_cnt[c] = m_rel[c];
                        else m_run[c] = 0;
                    end
                end
            end
        end
        m_ready = !acc;
    endtask

    task automatic check_all();
        chk("count0",  Count0,     m_cnt[0]);
        chk("count1",  Count1,     m_cnt[1]);
        chk("busy0",   W'(Busy0),    W'(m_run[0]));
        chk("busy1",   W'(Busy1),    W'(m_run[1]));
        chk("exp0",    W'(Expired0), W'(m_exp[0]));
        chk("exp1",    W'(Expired1), W'(m_exp[1]));
        chk("ready",   W'(Load_ready), W'(m_ready));
    endtask

    task automatic cyc(input bit en, input bit slt, input bit lv, input bit lsel,
                       input logic [W-1:0] lval, input bit lauto, input bit ab);
        @(negedge Clk);
        En = en; Slt = slt; Load_valid = lv; Load_sel = lsel;
        Load_value = lval; Load_auto = lauto; Abort = ab;
        @(posedge Clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset_n = 0; En = 0; Slt = 0; Load_valid = 0; Load_sel = 0;
        Load_value = '0; Load_auto = 0; Abort = 0;
        model_reset();
        #12;
        check_all();
        @(negedge Clk);
        Reset_n = 1;

        // ch0 single-shot countdown from 3
        cyc(0, 0, 1, 0, 3, 0, 0);
        chk("t2_load", Count0, 3);
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, 0, 0, '0, 0, 0);
            chk("t2_cnt", Count0, W'(3 - i));
        end
        chk("t2_exp", W'(Expired0), 1);
        chk("t2_busy", W'(Busy0), 0);
        cyc(1, 0, 0, 0, '0, 0, 0);
        chk("t2_pulse_end", W'(Expired0), 0);

        // ch1 prescaled countdown from 2
        cyc(0, 0, 1, 1, 2, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 0, 0, '0, 0, 0);
            if (i == 4) chk("t3_div", Count1, 1);
            if (i == 7) chk("t3_noexp", W'(Expired1), 0);
        end
        chk("t3_exp", W'(Expired1), 1);
        chk("t3_cnt", Count1, 0);

        // ch0 auto-reload
        cyc(0, 0, 1, 0, 2, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 0, 0, 0, '0, 0, 0);
            chk("t4_exp", W'(Expired0), W'(i % 2 == 0));
        end
        chk("t4_cnt", Count0, 2);
        chk("t4_busy", W'(Busy0), 1);
        cyc(0, 0, 0, 0, '0, 0, 1);
        chk("t4_abort", W'(Busy0), 0);

        // load with tick, then abort with load
        cyc(1, 0, 1, 0, 5, 0, 0);
        chk("t5_load_wins", Count0, 5);
        cyc(1, 0, 0, 0, '0, 0, 0);
        cyc(1, 0, 1, 0, 9, 0, 1);
        chk("t5_abort_hold", Count0, 4);
        chk("t5_abort_idle", W'(Busy0), 0);

        // zero load
        idle_cyc();
        cyc(0, 0, 1, 1, 5, 0, 0);
        idle_cyc();
        cyc(1, 1, 1, 1, 0, 0, 0);
        chk("t6_busy", W'(Busy1), 0);
        chk("t6_ready_lo", W'(Load_ready), 0);
        idle_cyc();
        chk("t6_ready_hi", W'(Load_ready), 1);
        chk("t6_noexp", W'(Expired1), 0);

        // async reset mid-run with Count1=7
        cyc(0, 0, 1, 1, 7, 0, 0);
        cyc(1, 0, 0, 0, '0, 0, 0);
        chk("t1_pre", Count1, 7);
        @(negedge Clk);
        #2;
        Reset_n = 0;
        #1;
        model_reset();
        chk("t1_count1", Count1, 0);
        chk("t1_busy1", W'(Busy1), 0);
        check_all();
        @(negedge Clk);
        Reset_n = 1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] v;
            if ($urandom % 8 == 0) v = {$urandom, $urandom};
            else v = W'($urandom % 10);
            cyc(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) == 0, $urandom % 2,
                v, $urandom % 2, ($urandom % 40) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
